// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and a word-organised dmem.
// Word-crossing accesses are split into two back-to-back word accesses when SPLIT_EN=1.
module lsu_ctrl #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ACC0 = 3'd1;
  localparam logic [2:0] ACC1 = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  // Byte enables of word 0 (hi=0) or word 1 (hi=1) for a size/offset pair.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off,
                                         input logic hi);
    logic [7:0] m;
    case (size)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'h00;
    endcase
    m = m << off;
    return hi ? m[7:4] : m[3:0];
  endfunction

  function automatic logic [31:0] lane_wd(input logic [31:0] wd, input logic [1:0] off,
                                          input logic hi);
    logic [63:0] w;
    w = {32'b0, wd} << {off, 3'b000};
    return hi ? w[63:32] : w[31:0];
  endfunction

  logic [2:0]  state, state_nx;
  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, lo_word;

  logic        accept, acc_split, r_split;
  logic [3:0]  acc_be0, r_be1;
  logic [31:0] acc_wd0, r_wd1;
  logic [63:0] rd64;
  logic [31:0] sh, rd_ext;

  assign accept    = req_valid && (state == IDLE);
  assign acc_be0   = lane_be(req_size, req_addr[1:0], 1'b0);
  assign acc_split = lane_be(req_size, req_addr[1:0], 1'b1) != 4'b0;
  assign acc_wd0   = lane_wd(req_wdata, req_addr[1:0], 1'b0);
  assign r_be1     = lane_be(r_size, r_addr[1:0], 1'b1);
  assign r_split   = r_be1 != 4'b0;
  assign r_wd1     = lane_wd(r_wdata, r_addr[1:0], 1'b1);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);

  always_comb begin
    rd64 = r_split ? {mem_rd, lo_word} : {32'b0, mem_rd};
    sh   = 32'(rd64 >> {r_addr[1:0], 3'b000});
    case (r_size)
      2'b00:   rd_ext = r_uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   rd_ext = r_uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: rd_ext = sh;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (req_size == 2'b11 || (acc_split && !SPLIT_EN)) state_nx = ERR;
        else                                                 state_nx = ACC0;
      end
      ACC0:    state_nx = r_split ? ACC1 : (r_we ? RESP : CAP);
      ACC1:    state_nx = r_we ? RESP : CAP;
      CAP:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      lo_word    <= '0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wd     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end

      // Memory port is registered: each access is loaded on the edge entering its state.
      if (state == IDLE && state_nx == ACC0) begin
        mem_addr <= req_addr[31:2];
        mem_be   <= acc_be0;
        mem_we   <= req_we && (acc_be0 != 4'b0);
        mem_wd   <= acc_wd0;
      end else if (state == ACC0 && state_nx == ACC1) begin
        mem_addr <= r_addr[31:2] + 30'd1;
        mem_be   <= r_be1;
        mem_we   <= r_we;
        mem_wd   <= r_wd1;
      end else begin
        mem_we <= 1'b0;
        mem_be <= '0;
        mem_wd <= '0;
      end

      if (state == ACC1 && !r_we) lo_word <= mem_rd;

      // Zero is loaded on entry to ERR / store RESP so it is already visible with resp_valid.
      if (state == CAP)
        resp_rdata <= rd_ext;
      else if (state_nx == ERR || state_nx == RESP)
        resp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: split and non-split instances, word-array dmem model.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_valid0, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_wd, mem_rd;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;

  logic        rdy0, rv0, re0, mwe0;
  logic [31:0] rdat0, mwd0;
  logic [3:0]  mbe0;
  logic [29:0] maddr0;
  logic [31:0] mem_rd0 = 32'hA5A5A5A5;

  lsu_ctrl #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  lsu_ctrl #(.SPLIT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(rdy0), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_err(re0), .resp_rdata(rdat0),
    .mem_we(mwe0), .mem_be(mbe0), .mem_addr(maddr0), .mem_wd(mwd0), .mem_rd(mem_rd0)
  );

  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[3:0]][8*i +: 8] <= mem_wd[8*i +: 8];
    mem_rd <= mem[mem_addr[3:0]];
  end

  logic [29:0] la[$];
  logic [3:0]  lb[$];
  logic        lw[$];
  logic [31:0] lwd[$];
  logic        dut0_act;
  always @(negedge clk) begin
    if (mem_be != 4'b0 || mem_we) begin
      la.push_back(mem_addr);
      lb.push_back(mem_be);
      lw.push_back(mem_we);
      lwd.push_back(mem_wd);
    end
    if (mbe0 != 4'b0 || mwe0) dut0_act = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic [29:0] a,
                         input logic [3:0] b, input logic w);
    if (idx < la.size()) begin
      check({tag, "_addr"}, 32'(la[idx]), 32'(a));
      check({tag, "_be"},   32'(lb[idx]), 32'(b));
      check({tag, "_we"},   32'(lw[idx]), 32'(w));
    end else
      check({tag, "_present"}, 32'(la.size()), 32'(idx + 1));
  endtask

  task automatic chk_wd(input string tag, input int idx, input logic [31:0] wd);
    if (idx < lwd.size()) check(tag, lwd[idx], wd);
    else                  check({tag, "_present"}, 32'(lwd.size()), 32'(idx + 1));
  endtask

  task automatic do_req(input logic which, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk);
    la.delete(); lb.delete(); lw.delete(); lwd.delete();
    dut0_act = 1'b0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    if (which) req_valid = 1'b1; else req_valid0 = 1'b1;
    check("ready_at_req", 32'(which ? req_ready : rdy0), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    // Scramble fields to confirm they were latched at accept.
    req_we = ~we; req_size = ~size; req_unsigned = ~uns; req_addr = ~addr; req_wdata = ~wd;
    lat = 0; err = 1'b0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (which ? resp_valid : rv0) begin
        lat = i;
        err = which ? resp_err : re0;
        rd  = which ? resp_rdata : rdat0;
        break;
      end
    end
    if (lat == 0) check("resp_seen", 32'(which ? resp_valid : rv0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          acc_n, resp_n;
  int          acc_c[3], resp_c[3];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_size = '0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rerr", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mwe", 32'(mem_we), 32'd0);
    check("rst_mbe", 32'(mem_be), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_mwd", mem_wd, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Aligned word store / load
    do_req(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, err, rd);
    check("stw_lat", 32'(lat), 32'd2);
    check("stw_err", 32'(err), 32'd0);
    check("stw_rd", rd, 32'd0);
    check("stw_nacc", 32'(la.size()), 32'd1);
    chk_acc("stw_a0", 0, 30'd4, 4'b1111, 1'b1);
    chk_wd("stw_wd0", 0, 32'hDEADBEEF);
    do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, lat, err, rd);
    check("ldw_lat", 32'(lat), 32'd3);
    check("ldw_rd", rd, 32'hDEADBEEF);
    chk_acc("ldw_a0", 0, 30'd4, 4'b1111, 1'b0);

    // Byte store, byte/half loads
    do_req(1, 1, 2'b00, 0, 32'h12, 32'h00000080, lat, err, rd);
    check("stb_lat", 32'(lat), 32'd2);
    chk_acc("stb_a0", 0, 30'd4, 4'b0100, 1'b1);
    chk_wd("stb_wd0", 0, 32'h00800000);
    do_req(1, 0, 2'b00, 0, 32'h12, 32'h0, lat, err, rd);
    check("ldb_s", rd, 32'hFFFFFF80);
    do_req(1, 0, 2'b00, 1, 32'h12, 32'h0, lat, err, rd);
    check("ldb_u", rd, 32'h00000080);
    do_req(1, 0, 2'b01, 1, 32'h12, 32'h0, lat, err, rd);
    check("ldh_u", rd, 32'h0000DE80);
    do_req(1, 0, 2'b01, 0, 32'h10, 32'h0, lat, err, rd);
    check("ldh_s", rd, 32'hFFFFBEEF);

    // Split halfword
    do_req(1, 1, 2'b10, 0, 32'h0, 32'h11223344, lat, err, rd);
    do_req(1, 1, 2'b10, 0, 32'h4, 32'h55667788, lat, err, rd);
    do_req(1, 0, 2'b01, 0, 32'h3, 32'h0, lat, err, rd);
    check("splh_lat", 32'(lat), 32'd4);
    check("splh_rd", rd, 32'hFFFF8811);
    check("splh_nacc", 32'(la.size()), 32'd2);
    chk_acc("splh_a0", 0, 30'd0, 4'b1000, 1'b0);
    chk_acc("splh_a1", 1, 30'd1, 4'b0001, 1'b0);
    do_req(1, 1, 2'b01, 0, 32'h3, 32'h0000AABB, lat, err, rd);
    check("spsh_lat", 32'(lat), 32'd3);
    chk_acc("spsh_a0", 0, 30'd0, 4'b1000, 1'b1);
    chk_acc("spsh_a1", 1, 30'd1, 4'b0001, 1'b1);
    chk_wd("spsh_wd0", 0, 32'hBB000000);
    chk_wd("spsh_wd1", 1, 32'h000000AA);
    do_req(1, 0, 2'b10, 0, 32'h0, 32'h0, lat, err, rd);
    check("spsh_w0", rd, 32'hBB223344);
    do_req(1, 0, 2'b10, 0, 32'h4, 32'h0, lat, err, rd);
    check("spsh_w1", rd, 32'h556677AA);

    // Address wrap
    do_req(1, 1, 2'b10, 0, 32'hFFFFFFFE, 32'h12345678, lat, err, rd);
    check("wrap_lat", 32'(lat), 32'd3);
    chk_acc("wrap_a0", 0, 30'h3FFFFFFF, 4'b1100, 1'b1);
    chk_acc("wrap_a1", 1, 30'd0, 4'b0011, 1'b1);
    chk_wd("wrap_wd0", 0, 32'h56780000);
    chk_wd("wrap_wd1", 1, 32'h00001234);
    do_req(1, 0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, lat, err, rd);
    check("wrap_ld_lat", 32'(lat), 32'd4);
    check("wrap_ld_rd", rd, 32'h12345678);
    do_req(1, 0, 2'b10, 0, 32'h0, 32'h0, lat, err, rd);
    check("wrap_w0", rd, 32'hBB221234);

    // Errors
    do_req(1, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, lat, err, rd);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_rd", rd, 32'd0);
    check("ill_nacc", 32'(la.size()), 32'd0);
    do_req(0, 0, 2'b10, 0, 32'h1, 32'h0, lat, err, rd);
    check("nosplit_lat", 32'(lat), 32'd1);
    check("nosplit_err", 32'(err), 32'd1);
    check("nosplit_rd", rd, 32'd0);
    check("nosplit_act", 32'(dut0_act), 32'd0);
    do_req(0, 0, 2'b00, 0, 32'h1, 32'h0, lat, err, rd);
    check("nosplit_b_lat", 32'(lat), 32'd3);
    check("nosplit_b_err", 32'(err), 32'd0);
    check("nosplit_b_rd", rd, 32'hFFFFFFA5);
    check("nosplit_b_act", 32'(dut0_act), 32'd1);

    // Reset during ACC1 of a split store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_acc0_be", 32'(mem_be), 32'h0000000E);
    @(negedge clk);
    check("rst_acc1_we", 32'(mem_we), 32'd1);
    check("rst_acc1_addr", 32'(mem_addr), 32'd9);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(req_ready), 32'd1);
    check("rst_rel_rvalid", 32'(resp_valid), 32'd0);
    do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, lat, err, rd);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_rd", rd, 32'hDE80BEEF);

    // Back-to-back aligned loads with req_valid held high
    acc_n = 0; resp_n = 0;
    foreach (acc_c[i]) begin acc_c[i] = -1; resp_c[i] = -1; end
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      if (acc_n >= 3) req_valid = 1'b0;
      if (resp_valid) begin
        if (resp_n < 3) begin
          resp_c[resp_n] = c;
          check("b2b_rd", resp_rdata, 32'hDE80BEEF);
        end
        resp_n++;
      end
      if (req_valid && req_ready) begin
        if (acc_n < 3) acc_c[acc_n] = c;
        acc_n++;
      end
    end
    req_valid = 1'b0;
    check("b2b_nacc", 32'(acc_n), 32'd3);
    check("b2b_nresp", 32'(resp_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_acc_cyc", 32'(acc_c[i]), 32'(4 * i));
      check("b2b_resp_cyc", 32'(resp_c[i]), 32'(4 * i + 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the pipeline memory stage and the word-organised data memory (`dmem`, 32-bit words, `we` + 4-bit byte enable, registered read).
- Accepts one byte, halfword or word request per transaction through a valid/ready handshake.
- Generates the word address, byte enables and lane-shifted write data for the memory, and sign- or zero-extends load data.
- Splits misaligned accesses that cross a word boundary into two back-to-back word accesses.

Parameters:
- SPLIT_EN, 1: 1 splits word-crossing accesses into two accesses; 0 answers them with an error and no memory access.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: illegal size, or misaligned with SPLIT_EN=0.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_addr  out  30  memory word address.
- mem_wd  out  32  memory write data, lane-aligned.
- mem_rd  in  32  memory read data; valid the cycle after the address is presented.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; req_ready = 1 (requests are not accepted while rst_n is low).
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_we = 0, mem_be = 0, mem_addr = 0, mem_wd = 0.
  - All latched request fields = 0.
  - Reset in any state aborts the transaction at once.
  - A split store aborted after ACC0 leaves the first word written. This is accepted.
- Handshake:
  - A request is accepted on the edge where req_valid and req_ready are both high.
  - All req_* fields are latched on that edge and need not be held afterwards.
  - One transaction is outstanding at a time.
- Lane math: off = addr[1:0]; nbytes = 1, 2 or 4.
  - be8 = ((1<<nbytes)-1) << off.
  - wd64 = zero-extended wdata << (8*off).
  - Word 0 uses be8[3:0] and wd64[31:0] at addr[31:2].
  - Word 1 uses be8[7:4] and wd64[63:32] at (addr[31:2]+1) mod 2^30, so 0x3FFFFFFF wraps to 0.
  - split = (be8[7:4] != 0).
- FSM states: IDLE, ACC0, ACC1, CAP, RESP, ERR.
  - IDLE: on accept go to ERR if size==11, or if split and SPLIT_EN==0. Otherwise go to ACC0.
  - ACC0: drive the word-0 access. mem_we = latched we and (be0 != 0).
    - Next: ACC1 if split; else CAP for a load; else RESP for a store.
  - ACC1: drive the word-1 access. If load, capture mem_rd as lo_word on the exit edge.
    - Next: CAP for a load, RESP for a store.
  - CAP: mem_rd holds the last-accessed word.
    - rd64 = split ? {mem_rd, lo_word} : {32'b0, mem_rd}.
    - Result = (rd64 >> 8*off), truncated to nbytes, then extended per req_unsigned.
    - The result is registered into resp_rdata. Next: RESP.
  - RESP: resp_valid = 1, resp_err = 0. Next: IDLE.
  - ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0, no memory access. Next: IDLE.
- Memory-port outputs outside ACC0/ACC1: mem_we = 0, mem_be = 0, mem_wd = 0; mem_addr holds its last value.
- During loads mem_we = 0, but mem_be still reflects the lanes being accessed.
- Latency from the accept edge to resp_valid high, in cycles:
  - aligned store: 2
  - split store: 3
  - aligned load: 3
  - split load: 4
  - error: 1
- req_ready = 0 from the accept edge until the cycle after RESP/ERR.
- Throughput: a new request may be accepted the cycle after resp_valid.
- resp_rdata is updated only in CAP, RESP or ERR; otherwise it holds.

Test Plan:
- Aligned word: store 0xDEADBEEF at addr 0x10, then load word from 0x10.
  - Store: mem_addr=4, mem_be=1111, resp 2 cycles after accept.
  - Load: resp_rdata=0xDEADBEEF, resp 3 cycles after accept.
- Byte store and loads: store byte 0x80 at addr 0x12, so mem_be=0100 and mem_wd=0x00800000.
  - Signed byte load from 0x12 returns 0xFFFFFF80.
  - Unsigned byte load from 0x12 returns 0x00000080.
- Split half (SPLIT_EN=1): word@0 = 0x11223344, word@4 = 0x55667788.
  - Signed half load from addr 3 issues two accesses: addr 0 with be=1000, then addr 1 with be=0001.
  - Returns 0xFFFF8811 (assembled half 0x8811, sign bit set).
  - Store of half 0xAABB at addr 3 writes byte 3 of word 0 = 0xBB and byte 0 of word 1 = 0xAA.
- Wrap and errors:
  - Word store at 0xFFFFFFFE: accesses mem_addr 0x3FFFFFFF with be=1100, then mem_addr 0 with be=0011.
  - Size 11: resp_err=1 one cycle after accept, mem_we never high.
  - SPLIT_EN=0 with a word load at addr 1: resp_err=1, no memory access.
- Reset mid-operation:
  - Drop rst_n during ACC1 of a split store: mem_we=0 immediately, and after release req_ready=1, resp_valid=0.
  - A following aligned load completes normally.
- Back-to-back: req_valid held high across 3 aligned loads.
  - Each is accepted the cycle after the previous resp_valid.
  - Exactly one resp_valid per request.
